// File: rtl/fir_sequencer.sv
// rtl/fir_sequencer.sv - stream-side initiator for the multi-cycle FIR filter.
// Buffers samples, issues one at a time to the filter and presents results on a stream.
module fir_sequencer #(
  parameter int M       = 24,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic signed [M-1:0]          src_data,
  input  logic                         src_valid,
  output logic                         src_ready,
  output logic signed [M-1:0]          fir_in,
  output logic                         fir_input_ready,
  input  logic signed [M-1:0]          fir_out,
  input  logic                         fir_output_ready,
  output logic signed [M-1:0]          dst_data,
  output logic                         dst_valid,
  input  logic                         dst_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t state, next_state;

  logic signed [M-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [WW-1:0]       wd;
  logic                push, pop, wd_clear, wd_inc, drop, capture;

  assign src_ready = (fill != FW'(DEPTH));
  assign push      = src_valid && src_ready;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state      = state;
    pop             = 1'b0;
    fir_input_ready = 1'b0;
    wd_clear        = 1'b0;
    wd_inc          = 1'b0;
    drop            = 1'b0;
    capture         = 1'b0;
    case (state)
      IDLE: begin
        // Holding off while the output slot is occupied bounds in-flight work to one sample.
        if (fill != '0 && !dst_valid) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        fir_input_ready = 1'b1;
        wd_clear        = 1'b1;
        next_state      = WAIT;
      end
      WAIT: begin
        if (fir_output_ready) begin
          next_state = CAPTURE;
        end else if (wd == WW'(TIMEOUT-1)) begin
          drop       = 1'b1;
          next_state = IDLE;
        end else begin
          wd_inc = 1'b1;
        end
      end
      CAPTURE: begin
        capture    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (push) mem[wr_ptr] <= src_data;
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      fir_in <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        fir_in <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wd          <= '0;
      timeout_err <= 1'b0;
      dst_data    <= '0;
      dst_valid   <= 1'b0;
    end else begin
      if (wd_clear)    wd <= '0;
      else if (wd_inc) wd <= wd + 1'b1;
      if (drop) timeout_err <= 1'b1;
      // The filter registers its result on the done edge, so fir_out is settled one cycle later.
      if (capture) begin
        dst_data  <= fir_out;
        dst_valid <= 1'b1;
      end else if (dst_valid && dst_ready) begin
        dst_valid <= 1'b0;
      end
    end
  end

endmodule
